matmul_controller: RTL

Parametrised square-matrix multiply sequencer: computes C = A × B for two DIM×DIM matrices held in an external synchronous-read memory. Results stream out over a valid/ready port with index and last markers. It sits between the loaded operand BRAM and the downstream result consumer (ILA or stream sink) and runs one multiply per `start` pulse. Each accumulator is cleared per output element; results never carry over between runs.

---
 rtl/matmul_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/matmul_controller.sv
// Square-matrix multiply sequencer: reads A and B from a synchronous-read memory,
// accumulates C = A x B one element at a time, then streams C out over valid/ready.
module matmul_controller #(
  parameter int DIM    = 3,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 8,
  parameter int B_BASE = DIM * DIM,
  parameter int SIGNED = 0,
  localparam int NEL   = DIM * DIM,
  localparam int IDX_W = (NEL > 1) ? $clog2(NEL) : 1,
  localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [ACC_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH_A = 3'd1;
  localparam logic [2:0] S_FETCH_B = 3'd2;
  localparam logic [2:0] S_MAC     = 3'd3;
  localparam logic [2:0] S_STREAM  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_i;
  logic [CNT_W-1:0]  r_j;
  logic [CNT_W-1:0]  r_k;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_a;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_result [NEL];

  logic [ADDR_W-1:0]   w_aAddr;
  logic [ADDR_W-1:0]   w_bAddr;
  logic [IDX_W-1:0]    w_elemIdx;
  logic [2*DATA_W-1:0] w_aExt;
  logic [2*DATA_W-1:0] w_bExt;
  logic [ACC_W-1:0]    w_prod;
  logic [ACC_W-1:0]    w_accNext;
  logic                w_kLast;
  logic                w_jLast;
  logic                w_iLast;
  logic                w_idxLast;

  assign w_aAddr   = ADDR_W'(int'(r_i) * DIM + int'(r_k));
  assign w_bAddr   = ADDR_W'(B_BASE + int'(r_k) * DIM + int'(r_j));
  assign w_elemIdx = IDX_W'(int'(r_i) * DIM + int'(r_j));

  assign w_kLast   = (r_k == CNT_W'(DIM - 1));
  assign w_jLast   = (r_j == CNT_W'(DIM - 1));
  assign w_iLast   = (r_i == CNT_W'(DIM - 1));
  assign w_idxLast = (r_idx == IDX_W'(NEL - 1));

  // Extending both operands to the full product width makes one unsigned multiply
  // serve both modes; the low bits of the product are identical for signed operands.
  assign w_aExt = (SIGNED != 0) ? {{DATA_W{r_a[DATA_W-1]}}, r_a}
                                : {{DATA_W{1'b0}}, r_a};
  assign w_bExt = (SIGNED != 0) ? {{DATA_W{mem_rd_data[DATA_W-1]}}, mem_rd_data}
                                : {{DATA_W{1'b0}}, mem_rd_data};
  assign w_prod    = ACC_W'(w_aExt * w_bExt);
  assign w_accNext = (r_k == '0) ? w_prod : r_acc + w_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_idx   <= '0;
            r_state <= S_FETCH_A;
          end
        end
        S_FETCH_A: r_state <= S_FETCH_B;
        S_FETCH_B: r_state <= S_MAC;
        S_MAC: begin
          if (!w_kLast) begin
            r_k     <= r_k + 1'b1;
            r_state <= S_FETCH_A;
          end else begin
            r_k <= '0;
            if (w_jLast) begin
              r_j <= '0;
              if (w_iLast) begin
                r_i     <= '0;
                r_state <= S_STREAM;
              end else begin
                r_i     <= r_i + 1'b1;
                r_state <= S_FETCH_A;
              end
            end else begin
              r_j     <= r_j + 1'b1;
              r_state <= S_FETCH_A;
            end
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (w_idxLast) begin
              r_idx   <= '0;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers and the result buffer carry no reset; every element is
  // rewritten before it can be streamed.
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH_B) begin
      r_a <= mem_rd_data;
    end
    if (r_state == S_MAC) begin
      r_acc <= w_accNext;
      if (w_kLast) begin
        r_result[w_elemIdx] <= w_accNext;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign mem_rd_en   = (r_state == S_FETCH_A) || (r_state == S_FETCH_B);
  assign mem_rd_addr = (r_state == S_FETCH_A) ? w_aAddr :
                       (r_state == S_FETCH_B) ? w_bAddr : '0;
  assign out_valid   = (r_state == S_STREAM);
  assign out_data    = (r_state == S_STREAM) ? r_result[r_idx] : '0;
  assign out_index   = r_idx;
  assign out_last    = (r_state == S_STREAM) && w_idxLast;

endmodule
